axi_rr_lock_arbiter: RTL



---
 rtl/axi_rr_lock_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/axi_rr_lock_arbiter.sv
// Round-robin arbiter with burst lock that drives the select input of an AXI N-to-1 channel mux.
// Optional feature: define AXI_ARB_PRIO_EN to add the prio_i port and a high-priority request class.
module axi_rr_lock_arbiter #(
    parameter int N_IN      = 16,
    parameter int SEL_WIDTH = $clog2(N_IN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_IN-1:0]      req_i,
    input  logic                 last_i,
`ifdef AXI_ARB_PRIO_EN
    input  logic [N_IN-1:0]      prio_i,
`endif
    input  logic                 ready_i,
    output logic [N_IN-1:0]      gnt_o,
    output logic                 valid_o,
    output logic [SEL_WIDTH-1:0] sel_o
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                 state;
    logic [SEL_WIDTH-1:0]   rr_ptr;
    logic [SEL_WIDTH-1:0]   lock_sel;
    logic [SEL_WIDTH-1:0]   winner;
    logic [SEL_WIDTH-1:0]   next_ptr;
    logic [N_IN-1:0]        scan_mask;
    logic                   handshake;

    // High-priority requesters, when any are present, hide everyone else from the scan.
    always_comb begin
        scan_mask = req_i;
`ifdef AXI_ARB_PRIO_EN
        if (|(req_i & prio_i)) begin
            scan_mask = req_i & prio_i;
        end
`endif
    end

    always_comb begin
        int  idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        winner = rr_ptr;
        for (int k = 0; k < N_IN; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_IN) begin
                idx = idx - N_IN;
            end
            if (!found && scan_mask[idx]) begin
                winner = SEL_WIDTH'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        if (state == LOCKED) begin
            sel_o   = lock_sel;
            valid_o = req_i[lock_sel];
        end else begin
            sel_o   = winner;
            valid_o = |req_i;
        end
    end

    assign handshake = valid_o & ready_i;

    always_comb begin
        gnt_o = '0;
        if (handshake) begin
            gnt_o[sel_o] = 1'b1;
        end
    end

    // Explicit wrap keeps rr_ptr below N_IN for non-power-of-two port counts.
    assign next_ptr = (sel_o == SEL_WIDTH'(N_IN - 1)) ? '0 : sel_o + SEL_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock_sel <= '0;
        end else if (handshake) begin
            if (last_i) begin
                state  <= IDLE;
                rr_ptr <= next_ptr;
            end else begin
                state    <= LOCKED;
                lock_sel <= sel_o;
            end
        end
    end

endmodule
